// File: rtl/adc_responder.sv
// adc_responder: device end of the serial ADC link.
// A frame is 16 bits on sdat, MSB first: four zeros and then a 12-bit sample.
// One bit is sent per clk edge.
// saddr is sampled at frame bits 2..4 to pick the channel that is loaded at
// bit 15 and sent in the following frame.
// Optional build macro ADC_RESP_RAMP_EN replaces chan_data with per-channel
// internal ramps. Channel k steps by k+1 on each load.
module adc_responder #(
  parameter int CHANNELS    = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_n,
  input  logic                     saddr,
  input  logic [CHANNELS*12-1:0]   chan_data,
  output logic                     sdat,
  output logic [2:0]               cur_ch,
  output logic                     frame_done,
  output logic [FRAME_CNT_W-1:0]   frame_cnt,
  output logic                     addr_err
);

  localparam logic [3:0] CH_LIMIT = 4'(CHANNELS);

  logic [3:0]             bit_cnt_reg;
  logic [11:0]            hold_reg;
  logic [2:0]             addr_reg;
  logic [2:0]             cur_ch_reg;
  logic                   sdat_reg;
  logic                   frame_done_reg;
  logic                   addr_err_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  logic                   frame_end;
  logic                   addr_in_range;
  logic                   sdat_next;
  logic [11:0]            load_value;
  logic [11:0]            sample_arr [8];

  assign frame_end     = !cs_n && (bit_cnt_reg == 4'd15);
  assign addr_in_range = ({1'b0, addr_reg} < CH_LIMIT);

`ifdef ADC_RESP_RAMP_EN
  // chan_data has no role when the internal ramps are the sample source.
  logic unused_chan_data;
  assign unused_chan_data = ^chan_data;
`endif

  // Sample sources for the eight possible addresses.
  // Slots at or above CHANNELS read as zero, so the mux never indexes past
  // the real channels.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_src
      if (gi < CHANNELS) begin : g_real
`ifdef ADC_RESP_RAMP_EN
        logic [11:0] ramp_reg;
        // The ramp advances by gi+1 each time this channel is loaded into hold.
        always_ff @(posedge clk) begin
          if (rst)
            ramp_reg <= 12'h000;
          else if (frame_end && (addr_reg == 3'(gi)))
            ramp_reg <= ramp_reg + 12'(gi + 1);
        end
        assign sample_arr[gi] = ramp_reg;
`else
        assign sample_arr[gi] = chan_data[gi*12 +: 12];
`endif
      end else begin : g_empty
        assign sample_arr[gi] = 12'h000;
      end
    end
  endgenerate

  assign load_value = addr_in_range ? sample_arr[addr_reg] : 12'h000;

  // Frame bit for the current edge.
  // The four leading zeros are followed by hold, MSB first.
  always_comb begin
    sdat_next = 1'b0;
    if (bit_cnt_reg >= 4'd4)
      sdat_next = hold_reg[4'd15 - bit_cnt_reg];
  end

  // Frame sequencing, address capture, and the conversion at the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg    <= 4'd0;
      sdat_reg       <= 1'b0;
      hold_reg       <= 12'h000;
      addr_reg       <= 3'd0;
      cur_ch_reg     <= 3'd0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      addr_err_reg   <= 1'b0;
    end else if (cs_n) begin
      // An abort keeps the previous conversion so that it can be sent again.
      bit_cnt_reg    <= 4'd0;
      sdat_reg       <= 1'b0;
      addr_reg       <= 3'd0;
      frame_done_reg <= 1'b0;
    end else begin
      bit_cnt_reg    <= bit_cnt_reg + 4'd1;
      sdat_reg       <= sdat_next;
      frame_done_reg <= frame_end;
      if (bit_cnt_reg >= 4'd2 && bit_cnt_reg <= 4'd4)
        addr_reg <= {addr_reg[1:0], saddr};
      if (frame_end) begin
        hold_reg      <= load_value;
        cur_ch_reg    <= addr_reg;
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
        if (!addr_in_range)
          addr_err_reg <= 1'b1;
      end
    end
  end

  assign sdat       = sdat_reg;
  assign cur_ch     = cur_ch_reg;
  assign frame_done = frame_done_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign addr_err   = addr_err_reg;

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- Synthesizable model of the serial ADC chip: the device end of the link driven by adc_interface.
- Responds to cs_n/saddr with 16-bit frames on sdat: 4 leading zeros, then a 12-bit sample, MSB first.
- Used for FPGA loopback and for simulation of the signal display chain without the real ADC.
- One bit per clk edge; the serial clock is the system clock, as on the board.

Parameters:
CHANNELS, 4, number of emulated input channels (1..8); chan_data width is CHANNELS*12
FRAME_CNT_W, 16, width of the completed-frame counter

Ports:
clk  input  1  system clock; also the serial bit clock
rst  input  1  synchronous, active-high reset
cs_n  input  1  chip select from the master, active low
saddr  input  1  serial address from the master (master's dout)
chan_data  input  CHANNELS*12  channel k sample at bits [12k+11:12k]
sdat  output  1  serial data to the master (master's din)
cur_ch  output  3  channel whose sample is being shifted in the current frame
frame_done  output  1  one-cycle pulse after each completed 16-bit frame
frame_cnt  output  FRAME_CNT_W  count of completed frames, wraps to 0
addr_err  output  1  sticky: an address >= CHANNELS was received

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - bit_cnt=0, sdat=0, hold=12'h000, cur_ch=0, addr=0.
  - frame_done=0, frame_cnt=0, addr_err=0.
  - Reset mid-frame abandons the frame immediately.
- Edge numbering: edge n=0 is the first clk edge with cs_n=0 while bit_cnt=0. The 4-bit bit_cnt counts edges 0..15 and wraps 15->0.
- sdat is registered. At edge n it takes frame bit n:
  - n=0..3: 0.
  - n=4..15: hold[15-n], so hold[11] goes out at edge 4.
  - Latency: the bit for edge n is visible on sdat from edge n until edge n+1.
- saddr is sampled at edges 2, 3, 4 into addr[2], addr[1], addr[0] (MSB first). saddr is ignored at all other edges.
- At edge 15:
  - hold <= chan_data[addr] and cur_ch <= addr; this is the conversion for the next frame.
  - If addr >= CHANNELS: hold <= 12'h000, cur_ch <= addr, addr_err <= 1.
  - frame_cnt increments; frame_done is high for the single cycle after edge 15.
- The channel addressed in frame N is output in frame N+1. The first frame after reset outputs 12'h000 from channel 0.
- If cs_n stays low, frames run back-to-back: the edge after edge 15 is edge 0 of the next frame, with no gap.
- cs_n=1 at any edge (abort):
  - bit_cnt <= 0, sdat <= 0, and the partial address is discarded.
  - hold, cur_ch and frame_cnt are unchanged; no frame_done pulse.
  - The next cs_n=0 edge starts a fresh frame at edge 0 with the old hold.
- cs_n=0 and rst=1 on the same edge: reset wins.
- chan_data is sampled only at edge 15. Changes at other times have no effect on the current frame.
- frame_cnt wraps from all-ones to 0 without any flag.

Optional Feature:
Macro ADC_RESP_RAMP_EN.
- Defined:
  - chan_data is ignored, and each channel k has an internal 12-bit ramp, reset to 0.
  - At every edge 15, the ramp of the channel just loaded into hold increments by k+1, wrapping modulo 4096.
  - hold is loaded with that ramp's value before the increment.
  - Out-of-range addresses still give 12'h000 and set addr_err.
- Not defined: no ramp registers exist, and hold comes from chan_data as above.

Test Plan:
- CHANNELS=4, ch0=12'hABC, saddr always 0, cs_n held low after reset:
  - frame 1 sdat = 16'h0000; frame 2 sdat = 16'h0ABC.
  - frame_done pulses once per 16 clks; frame_cnt reads 2 after frame 2.
- ch2=12'h5A5; frame 2 sends address 3'b010 at edges 2-4:
  - frame 3 sdat = 16'h05A5 and cur_ch=2.
  - frame 2 itself still carries the ch0 value.
- Frame sends address 3'b101 (CHANNELS=4) -> next frame sdat = 16'h0000, cur_ch=5, addr_err=1, staying 1 through later valid frames until rst.
- cs_n raised at edge 7 of a frame, ch1 addressed -> sdat=0 and frame_cnt unchanged; on the next cs_n low, the new frame reshifts the previous hold from edge 0.
- rst asserted at edge 9 with cs_n low:
  - all outputs return to reset values on the next cycle.
  - the next frame outputs 16'h0000.
  - 16 consecutive frames with frame_done pulsing exactly every 16 clks.
- ADC_RESP_RAMP_EN defined, saddr fixed to 3'b001 -> frames 2, 3, 4 after reset output 12'h000, 12'h002, 12'h004 on sdat; chan_data toggling has no effect.
